// File: rtl/dr_reqid_tracker_if.sv
// Bundles the allocation, grant, release and lookup channels of the DRID tracker.
// master: the request/ack side that drives allocations and releases.
// slave:  the tracker itself.
interface dr_reqid_tracker_if #(
  parameter int IdBits   = 6,
  parameter int NidBits  = 5,
  parameter int L2idBits = 6
);
  // allocation request
  logic                req_valid;
  logic                req_retry;
  logic [NidBits-1:0]  req_nid;
  logic [L2idBits-1:0] req_l2id;
  // allocated DRID
  logic                grant_valid;
  logic                grant_retry;
  logic [IdBits-1:0]   grant_drid;
  // release from memory ack
  logic                rel_valid;
  logic                rel_retry;
  logic [IdBits-1:0]   rel_drid;
  // lookup result for the snack
  logic                lkp_valid;
  logic                lkp_retry;
  logic [IdBits-1:0]   lkp_drid;
  logic [NidBits-1:0]  lkp_nid;
  logic [L2idBits-1:0] lkp_l2id;
  // status
  logic [IdBits:0]     free_count;
  logic                err_rel;

  modport master (
    output req_valid, req_nid, req_l2id, grant_retry, rel_valid, rel_drid, lkp_retry,
    input  req_retry, grant_valid, grant_drid, rel_retry, lkp_valid, lkp_drid, lkp_nid,
           lkp_l2id, free_count, err_rel
  );

  modport slave (
    input  req_valid, req_nid, req_l2id, grant_retry, rel_valid, rel_drid, lkp_retry,
    output req_retry, grant_valid, grant_drid, rel_retry, lkp_valid, lkp_drid, lkp_nid,
           lkp_l2id, free_count, err_rel
  );
endinterface

// File: rtl/dr_reqid_tracker.sv
// Purpose: allocates the lowest free DRID per L2 request, stores its {nid,l2id}, and on a
//          memory ack returns the stored context and frees the DRID.
// Latency: 1 cycle request->grant and release->lookup. Backpressure: retry on each channel;
//          grant/lookup are 1-entry fluid registers (accept while draining); full -> req_retry.
// Ports:   clk, reset (sync, active-high); bus (slave): req/grant/rel/lkp channels,
//          free_count (number of free DRIDs), err_rel (pulse on bad release).
module dr_reqid_tracker #(
  parameter int NumIds   = 64,
  parameter int IdBits   = $clog2(NumIds),
  parameter int NidBits  = 5,
  parameter int L2idBits = 6
) (
  input  logic             clk,
  input  logic             reset,
  dr_reqid_tracker_if.slave bus
);

  typedef struct packed {
    logic [NidBits-1:0]  nid;
    logic [L2idBits-1:0] l2id;
  } ctx_t;

  logic [NumIds-1:0] free_q;
  ctx_t              table_q [NumIds];
  logic [IdBits:0]   free_count_q;

  logic              grant_valid_q;
  logic [IdBits-1:0] grant_drid_q;
  logic              lkp_valid_q;
  logic [IdBits-1:0] lkp_drid_q;
  ctx_t              lkp_ctx_q;
  logic              err_rel_q;

  // Lowest-numbered free DRID; bit 0 is never free so it is skipped.
  logic [IdBits-1:0] alloc_drid;
  always_comb begin
    alloc_drid = '0;
    for (int i = NumIds - 1; i >= 1; i--) begin
      if (free_q[i]) alloc_drid = IdBits'(i);
    end
  end

  logic req_retry;
  logic req_acc;
  logic rel_retry;
  logic rel_acc;
  logic rel_in_range;
  logic rel_ok;
  logic rel_bad;

  assign req_retry = (free_count_q == '0) || (grant_valid_q && bus.grant_retry);
  assign req_acc   = bus.req_valid && !req_retry;
  assign rel_retry = lkp_valid_q && bus.lkp_retry;
  assign rel_acc   = bus.rel_valid && !rel_retry;

  // A release only produces a lookup when it names a DRID that is currently handed out.
  assign rel_in_range = 32'(bus.rel_drid) < NumIds;
  assign rel_ok  = rel_acc && rel_in_range && (bus.rel_drid != '0) && !free_q[bus.rel_drid];
  assign rel_bad = rel_acc && !rel_ok;

  // Free vector and count. The allocator picked from the pre-release vector, so a DRID
  // released this cycle cannot be the one allocated this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_q       <= {{(NumIds-1){1'b1}}, 1'b0};
      free_count_q <= (IdBits+1)'(NumIds - 1);
    end else begin
      if (req_acc) free_q[alloc_drid]   <= 1'b0;
      if (rel_ok)  free_q[bus.rel_drid] <= 1'b1;
      case ({rel_ok, req_acc})
        2'b10:   free_count_q <= free_count_q + 1'b1;
        2'b01:   free_count_q <= free_count_q - 1'b1;
        default: free_count_q <= free_count_q;
      endcase
    end
  end

  // Context table: write at alloc_drid and read at rel_drid never collide (one is free,
  // the other allocated), so no bypass is needed.
  always_ff @(posedge clk) begin
    if (req_acc) table_q[alloc_drid] <= '{nid: bus.req_nid, l2id: bus.req_l2id};
  end

  // Grant output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid_q <= 1'b0;
      grant_drid_q  <= '0;
    end else if (req_acc) begin
      grant_valid_q <= 1'b1;
      grant_drid_q  <= alloc_drid;
    end else if (grant_valid_q && !bus.grant_retry) begin
      grant_valid_q <= 1'b0;
    end
  end

  // Lookup output register and bad-release pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lkp_valid_q <= 1'b0;
      lkp_drid_q  <= '0;
      lkp_ctx_q   <= '0;
      err_rel_q   <= 1'b0;
    end else begin
      err_rel_q <= rel_bad;
      if (rel_ok) begin
        lkp_valid_q <= 1'b1;
        lkp_drid_q  <= bus.rel_drid;
        lkp_ctx_q   <= table_q[bus.rel_drid];
      end else if (lkp_valid_q && !bus.lkp_retry) begin
        lkp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_retry   = req_retry;
  assign bus.rel_retry   = rel_retry;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_drid  = grant_drid_q;
  assign bus.lkp_valid   = lkp_valid_q;
  assign bus.lkp_drid    = lkp_drid_q;
  assign bus.lkp_nid     = lkp_ctx_q.nid;
  assign bus.lkp_l2id    = lkp_ctx_q.l2id;
  assign bus.free_count  = free_count_q;
  assign bus.err_rel     = err_rel_q;

  // The counter must stay in range and agree with the free vector.
  a_count_range : assert property (@(posedge clk) disable iff (reset)
    32'(free_count_q) <= NumIds - 1);
  a_count_match : assert property (@(posedge clk) disable iff (reset)
    free_count_q == (IdBits+1)'($countones(free_q)));

endmodule
